// File: rtl/control_sequencer.sv
// control_sequencer: FETCH/EXEC sequencer for the LEGv8 control path.
// Holds IR, step state and {V,C,Z,N}; gates decoder control words.
module control_sequencer #(
  parameter int MAX_STEPS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        halt,
  input  logic [31:0] instr_in,
  input  logic        instr_valid,
  output logic        instr_req,
  output logic [31:0] ir,
  output logic [1:0]  state,
  output logic [3:0]  status,
  input  logic [30:0] dec_cw,
  input  logic [1:0]  dec_next_state,
  input  logic [3:0]  alu_status,
  input  logic        mem_ready,
  output logic [30:0] cw_out,
  output logic        instr_done,
  output logic        fault
);

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } fsm_t;

  localparam logic [1:0] LAST_STEP = 2'(MAX_STEPS - 1);

  fsm_t        fsm;
  fsm_t        fsm_d;
  logic [31:0] ir_d;
  logic [1:0]  state_d;
  logic [1:0]  step;
  logic [1:0]  step_d;
  logic [3:0]  status_d;
  logic        fault_d;
  logic        done_d;
  logic        mem_op;
  logic        step_ok;
  logic        last;

  assign mem_op    = dec_cw[7] | dec_cw[6];
  assign step_ok   = !mem_op || mem_ready;
  assign last      = (dec_next_state == 2'b00);
  assign instr_req = (fsm == FETCH) && !halt;

  // State register; synchronous reset overrides every field.
  always_ff @(posedge clock) begin
    if (reset) begin
      fsm        <= FETCH;
      ir         <= '0;
      state      <= 2'b00;
      status     <= 4'b0000;
      step       <= 2'b00;
      fault      <= 1'b0;
      instr_done <= 1'b0;
    end else begin
      fsm        <= fsm_d;
      ir         <= ir_d;
      state      <= state_d;
      status     <= status_d;
      step       <= step_d;
      fault      <= fault_d;
      instr_done <= done_d;
    end
  end

  // Next state, commit decisions and control-word gating.
  always_comb begin
    fsm_d    = fsm;
    ir_d     = ir;
    state_d  = state;
    status_d = status;
    step_d   = step;
    fault_d  = fault;
    done_d   = 1'b0;
    cw_out   = '0;
    unique case (fsm)
      FETCH: begin
        if (instr_valid && !halt) begin
          ir_d    = instr_in;
          state_d = 2'b00;
          step_d  = 2'b00;
          fsm_d   = EXEC;
        end
      end
      EXEC: begin
        cw_out = dec_cw;
        // Stalled steps keep the memory request but commit nothing.
        if (!step_ok) begin
          cw_out[8] = 1'b0;
          cw_out[0] = 1'b0;
        end
        if (!(step_ok && last)) begin
          cw_out[30:29] = 2'b00;
        end
        if (step_ok) begin
          if (dec_cw[0]) begin
            status_d = alu_status;
          end
          if (last) begin
            fsm_d   = FETCH;
            state_d = 2'b00;
            done_d  = 1'b1;
          end else if (step == LAST_STEP) begin
            fault_d = 1'b1;
            fsm_d   = FETCH;
            state_d = 2'b00;
          end else begin
            state_d = dec_next_state;
            step_d  = step + 2'd1;
          end
        end
      end
      default: begin
        fsm_d = FETCH;
      end
    endcase
  end

endmodule
